// File: rtl/cr_ifu_ibuf_if.sv
// -----------------------------------------------------------------------------
// cr_ifu_ibuf_if
// Handshake bundle between the IFU fetch/decode logic and the instruction
// buffer.
//   master : fetch/decode side (drives push, pop and flush, sees buffer status)
//   slave  : instruction buffer side
// Signals:
//   ifu_ibuf_flush            discard all buffered halfwords
//   ifu_ibuf_push_vld         fetch data valid
//   ifu_ibuf_push_upper_only  only push_data[31:16] is valid
//   ifu_ibuf_push_data        fetch data, low halfword is older
//   ibuf_ifu_push_rdy         at least two free entries
//   ifu_ibuf_pop              decode consumes the head instruction
//   ibuf_ifu_inst_vld         complete instruction at the head
//   ibuf_ifu_inst_data        {entry[rd+1], entry[rd]}
//   ibuf_ifu_inst_is32        head halfword opens a 32-bit instruction
//   ibuf_ifu_entry_cnt        occupied halfwords, 0..4
// -----------------------------------------------------------------------------
interface cr_ifu_ibuf_if;
   logic        ifu_ibuf_flush;
   logic        ifu_ibuf_push_vld;
   logic        ifu_ibuf_push_upper_only;
   logic [31:0] ifu_ibuf_push_data;
   logic        ibuf_ifu_push_rdy;
   logic        ifu_ibuf_pop;
   logic        ibuf_ifu_inst_vld;
   logic [31:0] ibuf_ifu_inst_data;
   logic        ibuf_ifu_inst_is32;
   logic [2:0]  ibuf_ifu_entry_cnt;

   modport master (
      output ifu_ibuf_flush, ifu_ibuf_push_vld, ifu_ibuf_push_upper_only,
             ifu_ibuf_push_data, ifu_ibuf_pop,
      input  ibuf_ifu_push_rdy, ibuf_ifu_inst_vld, ibuf_ifu_inst_data,
             ibuf_ifu_inst_is32, ibuf_ifu_entry_cnt
   );

   modport slave (
      input  ifu_ibuf_flush, ifu_ibuf_push_vld, ifu_ibuf_push_upper_only,
             ifu_ibuf_push_data, ifu_ibuf_pop,
      output ibuf_ifu_push_rdy, ibuf_ifu_inst_vld, ibuf_ifu_inst_data,
             ibuf_ifu_inst_is32, ibuf_ifu_entry_cnt
   );
endinterface

// File: rtl/cr_ifu_ibuf.sv
// -----------------------------------------------------------------------------
// cr_ifu_ibuf
// Four-entry 16-bit-halfword instruction buffer between fetch and decode.
// Accepts one or two halfwords per cycle and presents one 16- or 32-bit
// instruction per cycle. All outputs depend on registered state only.
// Ports:
//   forever_cpuclk                      clock
//   cpurst                              asynchronous active-high reset
//   ibuf                                handshake bundle (slave side)
//   randclk_ibuf_push_mod_en_w3         forced write-pointer clock enable
//   randclk_ibuf_pop_mod_en_w3          forced read-pointer clock enable
//   randclk_ibuf_entry_data_mod_en_w16  forced per-entry data clock enables
// -----------------------------------------------------------------------------
module cr_ifu_ibuf (
   input  logic                forever_cpuclk,
   input  logic                cpurst,
   cr_ifu_ibuf_if.slave        ibuf,
   input  logic                randclk_ibuf_push_mod_en_w3,
   input  logic                randclk_ibuf_pop_mod_en_w3,
   input  logic [3:0]          randclk_ibuf_entry_data_mod_en_w16
);

   logic [1:0]  wr_ptr, wr_ptr_nxt, wr_ptr_p1;
   logic [1:0]  rd_ptr, rd_ptr_nxt, rd_ptr_p1;
   logic [2:0]  cnt, cnt_nxt;
   logic [15:0] entry     [4];
   logic [15:0] entry_nxt [4];
   logic [3:0]  entry_we;
   logic [3:0]  entry_en;
   logic        wr_en, rd_en;
   logic        push_rdy, push_acc, pop_acc;
   logic        is32, inst_vld;
   logic [2:0]  push_dec, pop_dec;

   assign wr_ptr_p1 = wr_ptr + 2'd1;
   assign rd_ptr_p1 = rd_ptr + 2'd1;

   // Status is derived from registered state only; a same-cycle pop never
   // frees room for that cycle's push.
   assign push_rdy = (cnt <= 3'd2);
   assign is32     = (entry[rd_ptr][1:0] == 2'b11);
   assign inst_vld = (cnt != 3'd0) && (!is32 || (cnt >= 3'd2));

   assign ibuf.ibuf_ifu_push_rdy  = push_rdy;
   assign ibuf.ibuf_ifu_inst_vld  = inst_vld;
   assign ibuf.ibuf_ifu_inst_is32 = is32;
   assign ibuf.ibuf_ifu_inst_data = {entry[rd_ptr_p1], entry[rd_ptr]};
   assign ibuf.ibuf_ifu_entry_cnt = cnt;

   assign push_acc = ibuf.ifu_ibuf_push_vld & push_rdy & ~ibuf.ifu_ibuf_flush;
   assign pop_acc  = ibuf.ifu_ibuf_pop & inst_vld & ~ibuf.ifu_ibuf_flush;
   assign push_dec = !push_acc ? 3'd0 : (ibuf.ifu_ibuf_push_upper_only ? 3'd1 : 3'd2);
   assign pop_dec  = !pop_acc  ? 3'd0 : (is32 ? 3'd2 : 3'd1);

   always_comb begin
      // NOTE: every always_comb output is given a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      cnt_nxt    = cnt + push_dec - pop_dec;
      entry_we   = '0;
      for (int k = 0; k < 4; k++) entry_nxt[k] = entry[k];

      if (ibuf.ifu_ibuf_flush) begin
         // Flush only rewinds the pointers; entry data is left in place.
         wr_ptr_nxt = 2'd0;
         rd_ptr_nxt = 2'd0;
         cnt_nxt    = 3'd0;
      end else begin
         wr_ptr_nxt = wr_ptr + push_dec[1:0];
         rd_ptr_nxt = rd_ptr + pop_dec[1:0];
         if (push_acc) begin
            for (int k = 0; k < 4; k++) begin
               if (ibuf.ifu_ibuf_push_upper_only) begin
                  if (2'(k) == wr_ptr) begin
                     entry_nxt[k] = ibuf.ifu_ibuf_push_data[31:16];
                     entry_we[k]  = 1'b1;
                  end
               end else if (2'(k) == wr_ptr) begin
                  entry_nxt[k] = ibuf.ifu_ibuf_push_data[15:0];
                  entry_we[k]  = 1'b1;
               end else if (2'(k) == wr_ptr_p1) begin
                  entry_nxt[k] = ibuf.ifu_ibuf_push_data[31:16];
                  entry_we[k]  = 1'b1;
               end
            end
         end
      end

      // Forced random-clock enables only open the gate; the next-state value
      // equals the current value unless the group is functionally written.
      wr_en    = ibuf.ifu_ibuf_flush | push_acc | randclk_ibuf_push_mod_en_w3;
      rd_en    = ibuf.ifu_ibuf_flush | pop_acc  | randclk_ibuf_pop_mod_en_w3;
      entry_en = entry_we | randclk_ibuf_entry_data_mod_en_w16;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         cnt    <= 3'd0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr_nxt;
         if (rd_en) rd_ptr <= rd_ptr_nxt;
         cnt <= cnt_nxt;
      end
   end

   // NOTE: the entry array is reset deliberately: the head is visible on
   // inst_data/inst_is32 even when empty, so it must read as zero after reset.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         for (int k = 0; k < 4; k++) entry[k] <= 16'h0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (entry_en[k]) entry[k] <= entry_nxt[k];
         end
      end
   end

endmodule

// File: tb/tb_cr_ifu_ibuf.sv
// -----------------------------------------------------------------------------
// tb_cr_ifu_ibuf
// Self-checking bench for cr_ifu_ibuf. The reference model is a plain queue
// of halfwords; the driver pushes the expected post-edge view into a
// scoreboard and a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_cr_ifu_ibuf;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_mod_en = 1'b0;
   logic       pop_mod_en  = 1'b0;
   logic [3:0] entry_mod_en = 4'h0;

   cr_ifu_ibuf_if bus();

   cr_ifu_ibuf dut (
      .forever_cpuclk                     (clk),
      .cpurst                             (rst),
      .ibuf                               (bus),
      .randclk_ibuf_push_mod_en_w3        (push_mod_en),
      .randclk_ibuf_pop_mod_en_w3         (pop_mod_en),
      .randclk_ibuf_entry_data_mod_en_w16 (entry_mod_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [2:0]  cnt;
      logic        rdy;
      logic        vld;
      logic        is32;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mq[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   bit          rand_mod = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endtask

   // Architectural view of a halfword queue.
   function automatic exp_t model_view(input int due);
      exp_t e;
      int   n;
      n      = mq.size();
      e.due  = due;
      e.cnt  = 3'(n);
      e.rdy  = (n <= 2);
      e.is32 = (n > 0) && (mq[0][1:0] == 2'b11);
      e.vld  = (n >= 1) && (!e.is32 || n >= 2);
      e.data = 32'h0;
      if (n > 0) e.data[15:0] = mq[0];
      if (n > 1) e.data[31:16] = mq[1];
      return e;
   endfunction

   task automatic idle_inputs();
      bus.ifu_ibuf_flush           = 1'b0;
      bus.ifu_ibuf_push_vld        = 1'b0;
      bus.ifu_ibuf_push_upper_only = 1'b0;
      bus.ifu_ibuf_push_data       = 32'h0;
      bus.ifu_ibuf_pop             = 1'b0;
      push_mod_en  = 1'b0;
      pop_mod_en   = 1'b0;
      entry_mod_en = 4'h0;
   endtask

   // One cycle of stimulus: drive, advance the model, queue the expectation.
   task automatic step(input bit pv, input bit up, input logic [31:0] d,
                       input bit pp, input bit fl);
      exp_t pre;
      bus.ifu_ibuf_push_vld        = pv;
      bus.ifu_ibuf_push_upper_only = up;
      bus.ifu_ibuf_push_data       = d;
      bus.ifu_ibuf_pop             = pp;
      bus.ifu_ibuf_flush           = fl;
      if (rand_mod) begin
         push_mod_en  = 1'($urandom);
         pop_mod_en   = 1'($urandom);
         entry_mod_en = 4'($urandom);
      end
      pre = model_view(0);
      if (fl) begin
         mq.delete();
      end else begin
         if (pp && pre.vld) begin
            void'(mq.pop_front());
            if (pre.is32) void'(mq.pop_front());
         end
         if (pv && pre.rdy) begin
            if (up) mq.push_back(d[31:16]);
            else begin
               mq.push_back(d[15:0]);
               mq.push_back(d[31:16]);
            end
         end
      end
      exp_q.push_back(model_view(cyc + 1));
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   // Pointer-wrap scenario: a 32-bit instruction ends up split over 3 -> 0.
   task automatic wrap_run();
      step(0, 0, 32'h0, 0, 1);
      step(1, 0, 32'h2220_1110, 0, 0);
      step(1, 1, 32'h3330_0000, 0, 0);
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 1) step(1, 0, {16'h5550 + 16'(i), 16'h4403 + 16'(i << 4)}, 0, 0);
         else            step(0, 0, 32'h0, 1, 0);
      end
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 1, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
               check("late_record", cyc, e.due);
            end else begin
               check("entry_cnt", 32'(bus.ibuf_ifu_entry_cnt), 32'(e.cnt));
               check("push_rdy",  32'(bus.ibuf_ifu_push_rdy),  32'(e.rdy));
               check("inst_vld",  32'(bus.ibuf_ifu_inst_vld),  32'(e.vld));
               if (e.vld) begin
                  check("inst_is32", 32'(bus.ibuf_ifu_inst_is32), 32'(e.is32));
                  check("inst_lo", 32'(bus.ibuf_ifu_inst_data[15:0]), 32'(e.data[15:0]));
                  if (e.is32)
                     check("inst_hi", 32'(bus.ibuf_ifu_inst_data[31:16]), 32'(e.data[31:16]));
               end
            end
         end
      end
   end

   initial begin : driver
      idle_inputs();
      #2;
      check("rst_cnt",  32'(bus.ibuf_ifu_entry_cnt), 32'd0);
      check("rst_vld",  32'(bus.ibuf_ifu_inst_vld),  32'd0);
      check("rst_is32", 32'(bus.ibuf_ifu_inst_is32), 32'd0);
      check("rst_data", bus.ibuf_ifu_inst_data,      32'h0);
      check("rst_rdy",  32'(bus.ibuf_ifu_push_rdy),  32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic 16-bit push/pop.
      step(1, 0, 32'h0001_0002, 0, 0);
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 1, 0);

      // 32-bit instruction assembled from an odd-halfword fetch.
      step(1, 1, 32'h1233_0000, 0, 0);
      step(1, 0, 32'h5555_ABCD, 0, 0);
      step(0, 0, 32'h0, 1, 0);
      step(0, 0, 32'h0, 1, 0);

      // Fill to four, overflow attempt, push+pop at three.
      step(1, 0, 32'h2202_1101, 0, 0);
      step(1, 0, 32'h4404_3301, 0, 0);
      step(1, 0, 32'h6606_5501, 0, 0);
      step(0, 0, 32'h0, 1, 0);
      step(1, 0, 32'h8808_7701, 1, 0);

      // Wrap-around with quiet random-clock enables.
      wrap_run();

      // Flush beats simultaneous push and pop at cnt = 3.
      step(0, 0, 32'h0, 0, 1);
      step(1, 0, 32'h0204_0102, 0, 0);
      step(1, 1, 32'h0306_0000, 0, 0);
      step(1, 0, 32'h0a0a_0b0b, 1, 1);
      step(0, 0, 32'h0, 0, 0);

      // Steady 32-bit stream: one instruction per cycle, occupancy stays 2.
      for (int i = 0; i < 8; i++) step(1, 0, {16'h7000 + 16'(i), 16'h0013 + 16'(i << 4)}, 1, 0);
      step(0, 0, 32'h0, 1, 0);

      // Same wrap scenario with random-clock enables toggling every cycle.
      rand_mod = 1'b1;
      wrap_run();

      // Random traffic, random-clock enables on for the second half.
      rand_mod = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) rand_mod = 1'b1;
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom,
              $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
      end
      rand_mod = 1'b0;

      // Asynchronous reset mid-stream, away from any clock edge.
      step(1, 0, 32'hBEEF_C0DF, 0, 0);
      step(1, 0, 32'h1357_2469, 0, 0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_cnt",  32'(bus.ibuf_ifu_entry_cnt), 32'd0);
      check("midrst_vld",  32'(bus.ibuf_ifu_inst_vld),  32'd0);
      check("midrst_is32", 32'(bus.ibuf_ifu_inst_is32), 32'd0);
      check("midrst_data", bus.ibuf_ifu_inst_data,      32'h0);
      check("midrst_rdy",  32'(bus.ibuf_ifu_push_rdy),  32'd1);
      mq.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 32'h0, 1, 0);
      step(1, 0, 32'h0004_0003, 0, 0);
      step(0, 0, 32'h0, 0, 0);

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #6;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cr_ifu_ibuf.md
# cr_ifu_ibuf

Four-entry, 16-bit-halfword instruction buffer in the IFU, between the fetch datapath and decode. It accepts up to two halfwords per cycle from the 32-bit fetch bus and presents one 16-bit or 32-bit instruction per cycle to decode. It also consumes the random-clock module-enable signals from the IFU random-clock block. Those inputs force the push, pop and per-entry register clock enables open, and must not change functional behaviour.

## Interface
- No parameters. Fixed: 4 entries × 16 bits, 2-bit pointers.
- forever_cpuclk  in  1  single block clock
- cpurst  in  1  reset, asynchronous, active-high
- ifu_ibuf_flush  in  1  discard all contents
- ifu_ibuf_push_vld  in  1  fetch data valid
- ifu_ibuf_push_upper_only  in  1  1: only push_data[31:16] valid (odd-halfword fetch); 0: both halves valid
- ifu_ibuf_push_data  in  32  fetch data, low halfword is older
- ibuf_ifu_push_rdy  out  1  free entries ≥ 2
- ifu_ibuf_pop  in  1  decode consumes current instruction
- ibuf_ifu_inst_vld  out  1  a complete instruction is at the head
- ibuf_ifu_inst_data  out  32  {entry[rd+1], entry[rd]}; upper half is don't-care for 16-bit instructions
- ibuf_ifu_inst_is32  out  1  entry[rd][1:0] == 2'b11
- ibuf_ifu_entry_cnt  out  3  occupied halfwords, 0..4
- randclk_ibuf_push_mod_en_w3  in  1  force write-pointer clock enable
- randclk_ibuf_pop_mod_en_w3  in  1  force read-pointer clock enable
- randclk_ibuf_entry_data_mod_en_w16  in  4  per-entry forced data clock enable

## Operation
- State:
  - wr_ptr[1:0] and rd_ptr[1:0], both wrapping modulo 4.
  - cnt[2:0], range 0..4.
  - entry0..3[15:0].
- Push is accepted when push_vld & push_rdy & ~flush.
  - push_num = 1 if upper_only, else 2.
  - upper_only = 1: entry[wr] ← data[31:16].
  - upper_only = 0: entry[wr] ← data[15:0] and entry[wr+1] ← data[31:16].
  - wr_ptr += push_num.
  - A push while push_rdy = 0 is ignored. Fetch must hold the data and retry.
- Instruction valid and pop:
  - inst_vld = (cnt ≥ 1) & (~is32 | cnt ≥ 2).
  - A pop is accepted when pop & inst_vld & ~flush. It removes pop_num = 2 halfwords if is32, else 1.
  - rd_ptr += pop_num.
  - A pop while inst_vld = 0 is ignored.
- Count update: cnt_next = cnt + push_num·push_acc − pop_num·pop_acc.
  - Simultaneous push and pop are legal.
  - push_rdy is based on the current cnt only; a same-cycle pop does not free space for that cycle's push.
  - cnt can never exceed 4 or underflow.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: wr_ptr = rd_ptr = 0 and cnt = 0.
  - Entry data is not cleared.
- Random-clock inputs:
  - Each forced enable is ORed into its register group's clock enable: push group = wr_ptr, pop group = rd_ptr, entry k = entry k's data.
  - Every register holds its value unless it is functionally written, so asserting any mod_en bit has no architectural effect.

## Timing
- Reset, asynchronous assert: wr_ptr = rd_ptr = 0, cnt = 0, all entries = 16'h0.
- Output values during reset:
  - inst_vld = 0, inst_is32 = 0, inst_data = 32'h0.
  - push_rdy = 1, entry_cnt = 0.
- Reset asserted mid-operation discards all contents immediately. It does not wait for a clock edge.
- Latency: pushed data is visible at the head one cycle after the push edge. There is no same-cycle bypass.
- All outputs are combinational from registered state only. There is no combinational path from push, pop or flush inputs to any output.
- Wrap-around: a two-halfword push at wr_ptr = 3 writes entries 3 and 0. inst_data at rd_ptr = 3 is {entry0, entry3}.
- Throughput: with steady two-halfword fetch and 32-bit instructions, one instruction per cycle is sustained.

## Test plan
- Reset, then push 32'h0001_0002 (both halves) → next cycle cnt = 2, inst_vld = 1, is32 = 0 (2'b10), inst_data[15:0] = 16'h0002. Pop → cnt = 1, head = 16'h0001.
- Push an upper_only halfword 16'h1233 (32-bit opcode low half) with cnt = 0 → inst_vld = 0, cnt = 1. Push 32'hxxxx_ABCD with both halves → inst_vld = 1, is32 = 1, inst_data = 32'hABCD_1233.
- Fill to cnt = 4 → push_rdy = 0. A further push is ignored and cnt stays 4. At cnt = 3, push + pop of a 16-bit instruction → push is dropped (rdy = 0), cnt = 2.
- Wrap-around: 7 alternating push/pop cycles crossing the index-3→0 boundary → head data matches a reference queue in every cycle.
- Flush with simultaneous push and pop at cnt = 3 → next cycle cnt = 0, inst_vld = 0, push_rdy = 1. Assert cpurst mid-stream → outputs take their reset values asynchronously.
- Random-clock check: rerun the wrap-around scenario with all mod_en inputs randomized every cycle → outputs are cycle-identical to the mod_en = 0 run.
